// File: rtl/multicycle_core.sv
// multicycle_core: a small non-pipelined CPU that steps every instruction
// through IF -> ID -> EX -> MEM -> WB. Each instruction that does not halt
// takes exactly five cycles. HLT or an illegal opcode parks the core in HALT.
//
// Ports
//   clk, rst_n       single rising-edge clock; asynchronous active-low reset
//   start            pulse; honoured in IDLE/HALT, restarts execution at PC 0
//   prog_we/addr/    instruction-memory write port, honoured in IDLE/HALT only
//   prog_wdata
//   busy             high in IF/ID/EX/MEM/WB
//   halted           high in HALT
//   err              sticky illegal-opcode flag, cleared by start or reset
//   pc               current program counter
//   retired          count of retired instructions (wraps at 2^32)
module multicycle_core #(
   parameter int XLEN       = 32,
   parameter int IMEM_DEPTH = 1024,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          prog_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
   input  logic [31:0]                   prog_wdata,
   output logic                          busy,
   output logic                          halted,
   output logic                          err,
   output logic [$clog2(IMEM_DEPTH)-1:0] pc,
   output logic [31:0]                   retired
);
   localparam int IAW = $clog2(IMEM_DEPTH);
   localparam int DAW = $clog2(DMEM_DEPTH);

   localparam logic [5:0] OP_LD   = 6'b110000;
   localparam logic [5:0] OP_ST   = 6'b110001;
   localparam logic [5:0] OP_BEQZ = 6'b110100;
   localparam logic [5:0] OP_BNEZ = 6'b110101;
   localparam logic [5:0] OP_HLT  = 6'b111111;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
      S_MEM  = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
   } state_t;

   logic [31:0]     imem_q [IMEM_DEPTH];
   logic [XLEN-1:0] dmem_q [DMEM_DEPTH];
   logic [XLEN-1:0] rf_q   [32];

   state_t          state_q, state_d;
   logic [IAW-1:0]  pc_q, pc_d, target_q, target_d;
   logic [31:0]     ir_q, ir_d, retired_q, retired_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, dv_q, dv_d, imm_q, imm_d;
   logic [XLEN-1:0] res_q, res_d, lmd_q, lmd_d;
   logic            cond_q, cond_d, err_q, err_d, busy_q, busy_d, halted_q, halted_d;

   logic [5:0]      op_s;
   logic [4:0]      rd_s, rs1_s, rs2_s;
   logic [XLEN-1:0] imm_ext_s, rs1_val_s, rs2_val_s, rd_val_s, rf_wdata_s;
   logic            imem_we_s, dmem_we_s, rf_we_s;

   // Legal opcodes: ALU functions 0..5 (either operand-b source) plus LD/ST/BEQZ/BNEZ/HLT.
   function automatic logic op_legal(input logic [5:0] op);
      logic ok;
      if (op[5] == 1'b0) begin
         ok = (op[3:0] <= 4'd5);
      end else begin
         case (op)
            OP_LD, OP_ST, OP_BEQZ, OP_BNEZ, OP_HLT: ok = 1'b1;
            default:                                ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [XLEN-1:0] alu(input logic [3:0] fn, input logic [XLEN-1:0] a,
                                           input logic [XLEN-1:0] b);
      logic [XLEN-1:0] r;
      case (fn)
         4'd0:    r = a + b;
         4'd1:    r = a - b;
         4'd2:    r = a * b;                               // low XLEN bits of the product
         4'd3:    r = {{(XLEN-1){1'b0}}, (a > b)};         // unsigned compare
         4'd4:    r = a | b;
         4'd5:    r = a & b;
         default: r = {XLEN{1'b0}};
      endcase
      return r;
   endfunction

   assign op_s       = ir_q[31:26];
   assign rd_s       = ir_q[25:21];
   assign rs1_s      = ir_q[20:16];
   assign rs2_s      = ir_q[15:11];
   assign imm_ext_s  = XLEN'(signed'(ir_q[15:0]));
   assign imem_we_s  = prog_we && ((state_q == S_IDLE) || (state_q == S_HALT));
   // Gated by the registered state, so an async reset during MEM suppresses the store.
   assign dmem_we_s  = (state_q == S_MEM) && (op_s == OP_ST);
   assign rf_we_s    = (state_q == S_WB) && ((op_s[5] == 1'b0) || (op_s == OP_LD)) && (rd_s != 5'd0);
   assign rf_wdata_s = op_s[5] ? lmd_q : res_q;

   // Register-file read ports; r0 always reads as zero
   always_comb begin
      if (rs1_s == 5'd0) begin rs1_val_s = {XLEN{1'b0}}; end else begin rs1_val_s = rf_q[rs1_s]; end
      if (rs2_s == 5'd0) begin rs2_val_s = {XLEN{1'b0}}; end else begin rs2_val_s = rf_q[rs2_s]; end
      if (rd_s  == 5'd0) begin rd_val_s  = {XLEN{1'b0}}; end else begin rd_val_s  = rf_q[rd_s];  end
   end

   // Next-state and datapath-latch logic for the five-step instruction sequence
   always_comb begin
      state_d   = state_q;   pc_d   = pc_q;   target_d = target_q; ir_d  = ir_q;
      retired_d = retired_q; a_d    = a_q;    b_d      = b_q;      dv_d  = dv_q;
      imm_d     = imm_q;     res_d  = res_q;  lmd_d    = lmd_q;    cond_d = cond_q;
      err_d     = err_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_IF; pc_d = {IAW{1'b0}}; retired_d = 32'd0; err_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         S_IF: begin
            ir_d    = imem_q[pc_q];
            state_d = S_ID;
         end
         S_ID: begin
            a_d = rs1_val_s; b_d = rs2_val_s; dv_d = rd_val_s; imm_d = imm_ext_s;
            if (op_s == OP_HLT) begin
               state_d = S_HALT;
            end else if (!op_legal(op_s)) begin
               state_d = S_HALT; err_d = 1'b1;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            // Memory ops reuse the result latch as their address.
            if (op_s[5]) begin
               res_d = a_q + imm_q;
            end else begin
               res_d = alu(op_s[3:0], a_q, op_s[4] ? imm_q : b_q);
            end
            target_d = pc_q + IAW'(1'b1) + imm_q[IAW-1:0];
            cond_d   = ((op_s == OP_BEQZ) && (a_q == {XLEN{1'b0}})) ||
                       ((op_s == OP_BNEZ) && (a_q != {XLEN{1'b0}}));
            state_d  = S_MEM;
         end
         S_MEM: begin
            if (op_s == OP_LD) begin lmd_d = dmem_q[res_q[DAW-1:0]]; end else begin lmd_d = lmd_q; end
            state_d = S_WB;
         end
         S_WB: begin
            pc_d      = cond_q ? target_q : (pc_q + IAW'(1'b1));
            retired_d = retired_q + 32'd1;
            state_d   = S_IF;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
      halted_d = (state_d == S_HALT);
   end

   // Control FSM and all architectural/pipeline latches, async reset to IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE; pc_q <= {IAW{1'b0}}; target_q <= {IAW{1'b0}}; ir_q <= 32'd0;
         retired_q <= 32'd0; a_q <= {XLEN{1'b0}}; b_q <= {XLEN{1'b0}}; dv_q <= {XLEN{1'b0}};
         imm_q <= {XLEN{1'b0}}; res_q <= {XLEN{1'b0}}; lmd_q <= {XLEN{1'b0}};
         cond_q <= 1'b0; err_q <= 1'b0; busy_q <= 1'b0; halted_q <= 1'b0;
      end else begin
         state_q <= state_d; pc_q <= pc_d; target_q <= target_d; ir_q <= ir_d;
         retired_q <= retired_d; a_q <= a_d; b_q <= b_d; dv_q <= dv_d;
         imm_q <= imm_d; res_q <= res_d; lmd_q <= lmd_d;
         cond_q <= cond_d; err_q <= err_d; busy_q <= busy_d; halted_q <= halted_d;
      end
   end

   // Instruction memory program port
   always_ff @(posedge clk) begin
      if (imem_we_s) imem_q[prog_addr] <= prog_wdata;
   end

   // Data memory store port; address uses only the low index bits
   always_ff @(posedge clk) begin
      if (dmem_we_s) dmem_q[res_q[DAW-1:0]] <= dv_q;
   end

   // Register-file write port
   always_ff @(posedge clk) begin
      if (rf_we_s) rf_q[rd_s] <= rf_wdata_s;
   end

   assign busy    = busy_q;
   assign halted  = halted_q;
   assign err     = err_q;
   assign pc      = pc_q;
   assign retired = retired_q;
endmodule

// File: tb/tb_multicycle_core.sv
// Self-checking bench for multicycle_core: reset values, an ALU vector table,
// directed multi-cycle sequences, random programs against an instruction-level
// model, and a second XLEN=16 / 16-word instance for narrow-width and PC wrap.
module tb_multicycle_core;
   localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_MUL = 6'h02, OP_SGTU = 6'h03;
   localparam logic [5:0] OP_OR = 6'h04, OP_AND = 6'h05, OP_ADDI = 6'h10, OP_SUBI = 6'h11;
   localparam logic [5:0] OP_MULI = 6'h12, OP_SGTUI = 6'h13, OP_ORI = 6'h14, OP_ANDI = 6'h15;
   localparam logic [5:0] OP_LD = 6'h30, OP_ST = 6'h31, OP_BEQZ = 6'h34, OP_BNEZ = 6'h35;
   localparam logic [31:0] HLT_W = {6'h3F, 26'd0};

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, prog_we = 1'b0;
   logic [9:0]  prog_addr = 10'd0;
   logic [31:0] prog_wdata = 32'd0;
   logic busy, halted, err, busy16, halted16, err16;
   logic [9:0]  pc;
   logic [3:0]  pc16;
   logic [31:0] retired, retired16;
   int errors = 0, checks = 0;

   typedef struct { logic [5:0] op; logic [15:0] a; logic [15:0] b; logic [31:0] exp; } vec_t;
   vec_t vecs [15];
   logic [31:0] p [$];
   logic [31:0] m_reg [32];
   logic [31:0] m_dmem [1024];
   int m_pc, m_ret;
   bit m_err;
   logic [5:0] ill [8];

   always #5 clk = ~clk;

   multicycle_core #(.XLEN(32), .IMEM_DEPTH(1024), .DMEM_DEPTH(1024)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_wdata(prog_wdata), .busy(busy), .halted(halted), .err(err), .pc(pc), .retired(retired));

   multicycle_core #(.XLEN(16), .IMEM_DEPTH(16), .DMEM_DEPTH(16)) u16 (
      .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we), .prog_addr(prog_addr[3:0]),
      .prog_wdata(prog_wdata), .busy(busy16), .halted(halted16), .err(err16), .pc(pc16),
      .retired(retired16));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] op, input int rd, input int rs1, input int rs2);
      return {op, 5'(rd), 5'(rs1), 5'(rs2), 11'd0};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input int rd, input int rs1, input int imm);
      return {op, 5'(rd), 5'(rs1), 16'(imm)};
   endfunction

   task automatic load(input logic [31:0] prog [$]);
      for (int i = 0; i < prog.size(); i++) begin
         @(negedge clk);
         prog_we = 1'b1; prog_addr = 10'(i); prog_wdata = prog[i];
      end
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // sel: 0 main DUT, 1 narrow DUT, 2 both. Counts busy cycles of the selected DUT.
   task automatic run(input int sel, input int max_cyc, input int poke_at, input logic [9:0] poke_addr,
                      input logic [31:0] poke_data, output int cyc);
      bit finished;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0; finished = 1'b0;
      for (int n = 0; n < max_cyc; n++) begin
         finished = (sel == 0) ? halted : ((sel == 1) ? halted16 : (halted && halted16));
         if (finished) break;
         if ((sel == 1) ? busy16 : busy) cyc++;
         if (cyc == poke_at) begin
            start = 1'b1; prog_we = 1'b1; prog_addr = poke_addr; prog_wdata = poke_data;
         end else begin
            start = 1'b0; prog_we = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0; prog_we = 1'b0;
      check("run_terminates", 32'(finished), 32'd1);
   endtask

   task automatic wait_halt(input int maxc);
      int n;
      n = 0;
      while (!halted && n < maxc) begin @(negedge clk); n++; end
      check("wait_halt", 32'(halted), 32'd1);
   endtask

   // Instruction-level interpreter of the ISA (32-bit, 1024-word memories).
   task automatic model_run(input logic [31:0] prog [$]);
      logic [31:0] ins, a, b, imm, r;
      logic [5:0] op;
      int rd, rs1, rs2;
      bit done;
      m_pc = 0; m_ret = 0; m_err = 1'b0; done = 1'b0;
      for (int step = 0; step < 5000 && !done; step++) begin
         ins = prog[m_pc];
         op = ins[31:26]; rd = int'(ins[25:21]); rs1 = int'(ins[20:16]); rs2 = int'(ins[15:11]);
         imm = {{16{ins[15]}}, ins[15:0]};
         a = m_reg[rs1];
         b = op[4] ? imm : m_reg[rs2];
         if (op == 6'h3F) begin
            done = 1'b1;
         end else if (op[5] == 1'b0 && op[3:0] <= 4'd5) begin
            case (op[3:0])
               4'd0: r = a + b;
               4'd1: r = a - b;
               4'd2: r = a * b;
               4'd3: r = (a > b) ? 32'd1 : 32'd0;
               4'd4: r = a | b;
               default: r = a & b;
            endcase
            if (rd != 0) m_reg[rd] = r;
            m_pc = (m_pc + 1) % 1024; m_ret++;
         end else if (op == OP_LD) begin
            if (rd != 0) m_reg[rd] = m_dmem[int'((a + imm) & 32'h3FF)];
            m_pc = (m_pc + 1) % 1024; m_ret++;
         end else if (op == OP_ST) begin
            m_dmem[int'((a + imm) & 32'h3FF)] = m_reg[rd];
            m_pc = (m_pc + 1) % 1024; m_ret++;
         end else if (op == OP_BEQZ || op == OP_BNEZ) begin
            if ((op == OP_BEQZ) == (a == 32'd0)) m_pc = (m_pc + 1 + int'(imm)) & 1023;
            else m_pc = (m_pc + 1) % 1024;
            m_ret++;
         end else begin
            m_err = 1'b1; done = 1'b1;
         end
      end
   endtask

   initial begin
      int cyc;
      logic [5:0] op;
      vecs[0]  = '{OP_ADD,   16'd5,      16'd7,      32'd12};
      vecs[1]  = '{OP_SUB,   16'd5,      16'd7,      32'hFFFF_FFFE};
      vecs[2]  = '{OP_MUL,   16'hFFFF,   16'hFFFF,   32'd1};
      vecs[3]  = '{OP_MUL,   16'h7FFF,   16'h7FFF,   32'h3FFF_0001};
      vecs[4]  = '{OP_SGTU,  16'hFFFF,   16'd5,      32'd1};
      vecs[5]  = '{OP_SGTU,  16'd5,      16'hFFFF,   32'd0};
      vecs[6]  = '{OP_SGTU,  16'd7,      16'd7,      32'd0};
      vecs[7]  = '{OP_OR,    16'h0F0F,   16'h00FF,   32'h0000_0FFF};
      vecs[8]  = '{OP_AND,   16'h0F0F,   16'h00FF,   32'h0000_000F};
      vecs[9]  = '{OP_ADDI,  16'hFFFF,   16'd1,      32'd0};
      vecs[10] = '{OP_SUBI,  16'd3,      16'd5,      32'hFFFF_FFFE};
      vecs[11] = '{OP_ANDI,  16'h7FFF,   16'hFFF0,   32'h0000_7FF0};
      vecs[12] = '{OP_MULI,  16'hFFFD,   16'd4,      32'hFFFF_FFF4};
      vecs[13] = '{OP_ORI,   16'h8000,   16'h0001,   32'hFFFF_8001};
      vecs[14] = '{OP_SGTUI, 16'h0001,   16'h8000,   32'd0};
      ill[0] = 6'h06; ill[1] = 6'h0F; ill[2] = 6'h16; ill[3] = 6'h1F;
      ill[4] = 6'h20; ill[5] = 6'h32; ill[6] = 6'h37; ill[7] = 6'h3E;

      // Reset values
      #1;
      check("rst_busy", 32'(busy), 32'd0);       check("rst_halted", 32'(halted), 32'd0);
      check("rst_err", 32'(err), 32'd0);         check("rst_pc", 32'(pc), 32'd0);
      check("rst_retired", retired, 32'd0);      check("rst_ir", dut.ir_q, 32'd0);
      check("rst16_busy", 32'(busy16), 32'd0);   check("rst16_halted", 32'(halted16), 32'd0);
      check("rst16_pc", 32'(pc16), 32'd0);       check("rst16_retired", retired16, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Basic program, with start and prog_we poked mid-run (both must be ignored)
      p.delete();
      p.push_back(enc_i(OP_ADDI, 1, 0, 5)); p.push_back(enc_i(OP_ADDI, 2, 0, 7));
      p.push_back(enc_r(OP_ADD, 3, 1, 2));  p.push_back(HLT_W);
      load(p);
      run(0, 200, 6, 10'd3, enc_i(OP_ADDI, 4, 0, 1), cyc);
      check("basic_r3", dut.rf_q[3], 32'd12);      check("basic_retired", retired, 32'd3);
      check("basic_cycles", 32'(cyc), 32'd17);      check("basic_pc", 32'(pc), 32'd3);
      check("busy_we_ignored", dut.imem_q[3], HLT_W);

      // ALU vector table
      for (int i = 0; i < 15; i++) begin
         p.delete();
         p.push_back(enc_i(OP_ADDI, 1, 0, int'(vecs[i].a)));
         p.push_back(enc_i(OP_ADDI, 2, 0, int'(vecs[i].b)));
         p.push_back(vecs[i].op[4] ? enc_i(vecs[i].op, 3, 1, int'(vecs[i].b)) : enc_r(vecs[i].op, 3, 1, 2));
         p.push_back(HLT_W);
         load(p);
         run(0, 200, -1, 10'd0, 32'd0, cyc);
         check($sformatf("vec%0d_r3", i), dut.rf_q[3], vecs[i].exp);
         check($sformatf("vec%0d_retired", i), retired, 32'd3);
      end

      // Store then load
      p.delete();
      p.push_back(enc_i(OP_ADDI, 1, 0, 10)); p.push_back(enc_i(OP_ST, 1, 0, 4));
      p.push_back(enc_i(OP_LD, 2, 0, 4));    p.push_back(HLT_W);
      load(p); run(0, 200, -1, 10'd0, 32'd0, cyc);
      check("stld_dmem4", dut.dmem_q[4], 32'd10); check("stld_r2", dut.rf_q[2], 32'd10);

      // Countdown loop with a backward branch
      p.delete();
      p.push_back(enc_i(OP_ADDI, 1, 0, 3)); p.push_back(enc_i(OP_SUBI, 1, 1, 1));
      p.push_back(enc_i(OP_BNEZ, 0, 1, -2)); p.push_back(HLT_W);
      load(p); run(0, 400, -1, 10'd0, 32'd0, cyc);
      check("loop_r1", dut.rf_q[1], 32'd0);     check("loop_retired", retired, 32'd7);
      check("loop_cycles", 32'(cyc), 32'd37);   check("loop_pc", 32'(pc), 32'd3);

      // Illegal opcode at PC 2, then start must clear err
      p.delete();
      p.push_back(enc_i(OP_ADDI, 1, 0, 1)); p.push_back(enc_i(OP_ADDI, 2, 0, 2));
      p.push_back({6'b000111, 26'd0});       p.push_back(HLT_W);
      load(p); run(0, 200, -1, 10'd0, 32'd0, cyc);
      check("ill_halted", 32'(halted), 32'd1);  check("ill_err", 32'(err), 32'd1);
      check("ill_pc", 32'(pc), 32'd2);          check("ill_retired", retired, 32'd2);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("restart_err", 32'(err), 32'd0);    check("restart_busy", 32'(busy), 32'd1);
      check("restart_pc", 32'(pc), 32'd0);      check("restart_retired", retired, 32'd0);
      wait_halt(100);
      check("reill_err", 32'(err), 32'd1);

      // prog_we and start in the same parked cycle: the new word executes
      p.delete(); p.push_back(enc_i(OP_ADDI, 5, 0, 1)); p.push_back(HLT_W);
      load(p);
      @(negedge clk);
      start = 1'b1; prog_we = 1'b1; prog_addr = 10'd0; prog_wdata = enc_i(OP_ADDI, 5, 0, 2);
      @(negedge clk); start = 1'b0; prog_we = 1'b0;
      wait_halt(100);
      check("we_start_r5", dut.rf_q[5], 32'd2);

      // Reset asserted while a store sits in MEM: the store must not land
      p.delete();
      p.push_back(enc_i(OP_ADDI, 1, 0, 55)); p.push_back(enc_i(OP_ST, 1, 0, 6)); p.push_back(HLT_W);
      load(p); run(0, 200, -1, 10'd0, 32'd0, cyc);
      check("pre_dmem6", dut.dmem_q[6], 32'd55);
      p[0] = enc_i(OP_ADDI, 1, 0, 99);
      load(p);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_retired", retired, 32'd1);
      rst_n = 1'b0; #1;
      check("mreset_busy", 32'(busy), 32'd0);   check("mreset_halted", 32'(halted), 32'd0);
      check("mreset_err", 32'(err), 32'd0);     check("mreset_pc", 32'(pc), 32'd0);
      check("mreset_retired", retired, 32'd0);  check("mreset_ir", dut.ir_q, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("mreset_dmem6", dut.dmem_q[6], 32'd55);

      // Random programs against the instruction-level model
      for (int t = 0; t < 20; t++) begin
         p.delete();
         for (int r = 1; r < 16; r++) p.push_back(enc_i(OP_ADDI, r, 0, int'($urandom_range(0, 65535))));
         for (int k = 0; k < 8; k++) p.push_back(enc_i(OP_ST, (k % 15) + 1, 0, k));
         for (int k = 0; k < 20; k++) begin
            int kind, rd, rs1, rs2, addr;
            kind = int'($urandom_range(0, 9));
            rd = int'($urandom_range(0, 15)); rs1 = int'($urandom_range(0, 15)); rs2 = int'($urandom_range(0, 15));
            addr = int'($urandom_range(0, 7)) + 1024 * (int'($urandom_range(0, 6)) - 3);
            op = {2'b00, 4'($urandom_range(0, 5))} | (($urandom_range(0, 1) == 1) ? 6'h10 : 6'h00);
            if (kind == 9 && $urandom_range(0, 3) == 0) op = ill[$urandom_range(0, 7)];
            if (kind == 6) p.push_back(enc_i(OP_LD, rd, 0, addr));
            else if (kind == 7) p.push_back(enc_i(OP_ST, rd, 0, addr));
            else if (kind == 8) p.push_back(enc_i(($urandom_range(0, 1) == 1) ? OP_BEQZ : OP_BNEZ, 0, rs1,
                                                  int'($urandom_range(0, 2))));
            else if (op[4]) p.push_back(enc_i(op, rd, rs1, int'($urandom_range(0, 65535))));
            else p.push_back(enc_r(op, rd, rs1, rs2));
         end
         p.push_back(HLT_W); p.push_back(HLT_W); p.push_back(HLT_W);
         for (int r = 0; r < 32; r++) m_reg[r] = 32'd0;
         model_run(p);
         load(p);
         run(0, 2000, -1, 10'd0, 32'd0, cyc);
         check($sformatf("rnd%0d_halted", t), 32'(halted), 32'd1);
         check($sformatf("rnd%0d_err", t), 32'(err), 32'(m_err));
         check($sformatf("rnd%0d_pc", t), 32'(pc), 32'(m_pc));
         check($sformatf("rnd%0d_retired", t), retired, 32'(m_ret));
         check($sformatf("rnd%0d_cycles", t), 32'(cyc), 32'(5 * m_ret + 2));
         for (int r = 1; r < 16; r++) check($sformatf("rnd%0d_r%0d", t, r), dut.rf_q[r], m_reg[r]);
         for (int k = 0; k < 8; k++) check($sformatf("rnd%0d_m%0d", t, k), dut.dmem_q[k], m_dmem[k]);
      end

      // Narrow instance: 16-bit multiply truncation and sign-extended immediate
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      p.delete();
      p.push_back(enc_i(OP_ADDI, 1, 0, 256)); p.push_back(enc_r(OP_MUL, 2, 1, 1));
      p.push_back(enc_i(OP_ADDI, 3, 0, -1));  p.push_back(HLT_W);
      load(p); run(2, 200, -1, 10'd0, 32'd0, cyc);
      check("x16_mul", 32'(u16.rf_q[2]), 32'h0000_0000);
      check("x16_neg1", 32'(u16.rf_q[3]), 32'h0000_FFFF);
      check("x16_retired", retired16, 32'd3);
      check("x32_mul", dut.rf_q[2], 32'h0001_0000);

      // Narrow instance: branch target below 0 wraps to the last word
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      p.delete();
      p.push_back(enc_i(OP_BEQZ, 0, 0, -2));
      for (int i = 1; i < 15; i++) p.push_back(32'd0);
      p.push_back(HLT_W);
      load(p); run(1, 200, -1, 10'd0, 32'd0, cyc);
      check("wrap_pc", 32'(pc16), 32'd15);
      check("wrap_retired", retired16, 32'd1);
      check("wrap_err", 32'(err16), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
